// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
//
// Purpose:
//   Runtime-programmable baud tick generator for the UART. A fixed-point
//   divisor {integer, fraction} sets the oversample interval. A fractional
//   accumulator stretches some intervals by one cycle, so the average rate
//   does not drift. The block produces single-cycle oversample, mid-bit and
//   bit-boundary ticks. It also keeps a legacy square-wave output.
//
// Ports:
//   i_clk       clock
//   i_rst       synchronous, active-high reset (highest priority)
//   i_enable    run counters; when low all counting state holds
//   i_resync    restart the tick phase (counter, accumulator, os counter)
//   i_div_wr    divisor write strobe
//   i_div_in    new divisor {integer[DIV_WIDTH], fraction[FRAC_WIDTH]}
//   o_div_q     active divisor
//   o_div_err   one-cycle pulse when a write is rejected (integer part < 2)
//   o_os_tick   oversample tick, one cycle wide
//   o_mid_tick  mid-bit tick, coincides with the os_tick that reaches OS/2
//   o_bit_tick  bit-boundary tick, coincides with the os_tick that wraps
//   o_baud_clk  legacy square wave, toggles on every os_tick
// -----------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int     CLK_FREQ     = 50000000,
    parameter int     DEFAULT_BAUD = 19200,
    parameter int     OVERSAMPLE   = 16,
    parameter int     DIV_WIDTH    = 16,
    parameter int     FRAC_WIDTH   = 4,
    // round(CLK_FREQ * 2^FRAC_WIDTH / (DEFAULT_BAUD * OVERSAMPLE))
    parameter longint DEFAULT_DIV  =
        ((longint'(CLK_FREQ) << (FRAC_WIDTH + 1)) + longint'(DEFAULT_BAUD) * OVERSAMPLE)
        / (2 * longint'(DEFAULT_BAUD) * OVERSAMPLE)
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_enable,
    input  logic                            i_resync,
    input  logic                            i_div_wr,
    input  logic [DIV_WIDTH+FRAC_WIDTH-1:0] i_div_in,
    output logic [DIV_WIDTH+FRAC_WIDTH-1:0] o_div_q,
    output logic                            o_div_err,
    output logic                            o_os_tick,
    output logic                            o_mid_tick,
    output logic                            o_bit_tick,
    output logic                            o_baud_clk
);

    localparam int DW   = DIV_WIDTH + FRAC_WIDTH;
    localparam int CW   = DIV_WIDTH + 1;
    localparam int OS_W = $clog2(OVERSAMPLE);

    localparam logic [DW-1:0]   DEF_DIV = DW'(DEFAULT_DIV);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    // State
    logic [DW-1:0]         r_div;
    logic [DW-1:0]         r_pend;
    logic                  r_pend_valid;
    logic [CW-1:0]         r_cnt;
    logic [FRAC_WIDTH-1:0] r_acc;
    logic [OS_W-1:0]       r_os_cnt;
    logic                  r_os_tick;
    logic                  r_mid_tick;
    logic                  r_bit_tick;
    logic                  r_baud_clk;
    logic                  r_div_err;

    // Combinational helpers
    logic [DIV_WIDTH-1:0]  w_div_int;
    logic [FRAC_WIDTH-1:0] w_div_frac;
    logic [FRAC_WIDTH:0]   w_sum;
    logic                  w_carry;
    logic [CW-1:0]         w_period;
    logic                  w_last;
    logic                  w_int_end;
    logic                  w_wr_ok;
    logic                  w_apply;

    assign w_div_int  = r_div[DW-1:FRAC_WIDTH];
    assign w_div_frac = r_div[FRAC_WIDTH-1:0];

    // The carry out of the fractional sum stretches this interval by one cycle.
    assign w_sum    = {1'b0, r_acc} + {1'b0, w_div_frac};
    assign w_carry  = w_sum[FRAC_WIDTH];
    assign w_period = {1'b0, w_div_int} + {{DIV_WIDTH{1'b0}}, w_carry};

    // Use >= instead of ==. The divisor can shrink while the counter holds
    // with enable low, and the counter must not run past the new period.
    assign w_last    = (r_cnt >= (w_period - CW'(1)));
    assign w_int_end = i_enable && !i_resync && w_last;

    assign w_wr_ok = i_div_wr && (i_div_in[DW-1:FRAC_WIDTH] >= DIV_WIDTH'(2));

    // The pending divisor is taken at an interval boundary. With the counters
    // frozen there is no boundary to wait for, so it is taken at once.
    assign w_apply = r_pend_valid && (w_int_end || !i_enable);

    // NOTE: sequential state uses non-blocking assignments only. Every register
    // then samples the pre-edge values, whatever order the statements are in.
    always_ff @(posedge i_clk) begin
        // NOTE: reset is synchronous. It is tested first, so it overrides
        // enable, resync and any divisor write in the same cycle.
        if (i_rst) begin
            r_div        <= DEF_DIV;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_os_cnt     <= '0;
            r_os_tick    <= 1'b0;
            r_mid_tick   <= 1'b0;
            r_bit_tick   <= 1'b0;
            r_baud_clk   <= 1'b0;
            r_div_err    <= 1'b0;
        end else begin
            r_div_err <= i_div_wr && !w_wr_ok;

            // Tick pulses last one cycle. They are high only after an interval end.
            r_os_tick  <= w_int_end;
            r_mid_tick <= w_int_end && (r_os_cnt == OS_MID);
            r_bit_tick <= w_int_end && (r_os_cnt == OS_LAST);

            // Phase counters. resync wins even when enable is low.
            if (i_resync) begin
                r_cnt    <= '0;
                r_acc    <= '0;
                r_os_cnt <= '0;
            end else if (w_int_end) begin
                r_cnt      <= '0;
                r_acc      <= w_sum[FRAC_WIDTH-1:0];
                r_os_cnt   <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + OS_W'(1);
                r_baud_clk <= ~r_baud_clk;
            end else if (i_enable) begin
                r_cnt <= r_cnt + CW'(1);
            end

            // Divisor update. A valid write together with resync takes effect
            // at once, because the phase restarts anyway.
            if (w_wr_ok && i_resync) begin
                r_div        <= i_div_in;
                r_pend_valid <= 1'b0;
            end else begin
                if (w_apply) begin
                    r_div <= r_pend;
                end
                // A new write keeps pending valid. The last write wins.
                if (w_wr_ok) begin
                    r_pend       <= i_div_in;
                    r_pend_valid <= 1'b1;
                end else if (w_apply) begin
                    r_pend_valid <= 1'b0;
                end
            end
        end
    end

    assign o_div_q    = r_div;
    assign o_div_err  = r_div_err;
    assign o_os_tick  = r_os_tick;
    assign o_mid_tick = r_mid_tick;
    assign o_bit_tick = r_bit_tick;
    assign o_baud_clk = r_baud_clk;

endmodule

// File: tb/tb_baud_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_baud_tick_gen
//
// Purpose:
//   Directed testbench for baud_tick_gen with the default parameters.
//   Expected interval lengths, tick positions and divisor values are worked
//   out by hand from the fixed-point divisor arithmetic.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_baud_tick_gen;

    localparam int DW = 20;
    localparam logic [31:0] DEF_DIV = 32'h0000_0A2C;   // 2604 = {162, 12}

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          resync;
    logic          div_wr;
    logic [DW-1:0] div_in;
    logic [DW-1:0] div_q;
    logic          div_err;
    logic          os_tick;
    logic          mid_tick;
    logic          bit_tick;
    logic          baud_clk;

    int   n_asserts = 0;
    int   n_fail    = 0;
    logic exp_baud  = 1'b0;

    baud_tick_gen dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_enable   (enable),
        .i_resync   (resync),
        .i_div_wr   (div_wr),
        .i_div_in   (div_in),
        .o_div_q    (div_q),
        .o_div_err  (div_err),
        .o_os_tick  (os_tick),
        .o_mid_tick (mid_tick),
        .o_bit_tick (bit_tick),
        .o_baud_clk (baud_clk)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock. Sample 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count cycles up to the next os_tick, with a bounded wait. A timeout
    // returns the bound, so the caller's interval check fails.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!os_tick && n < 400);
        if (os_tick) exp_baud = ~exp_baud;
    endtask

    initial begin
        int n;
        int sum;
        logic any_tick;
        logic baud_moved;

        rst    = 1'b1;
        enable = 1'b1;
        resync = 1'b0;
        div_wr = 1'b0;
        div_in = '0;
        step();
        step();

        // ---- reset state ----
        check("rst_div_q",    32'(div_q), DEF_DIV);
        check("rst_os_tick",  32'(os_tick), 0);
        check("rst_mid_tick", 32'(mid_tick), 0);
        check("rst_bit_tick", 32'(bit_tick), 0);
        check("rst_baud_clk", 32'(baud_clk), 0);
        check("rst_div_err",  32'(div_err), 0);
        rst = 1'b0;

        // ---- defaults: intervals 162,163,163,163 repeating, total 2604 ----
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            wait_tick(n);
            sum += n;
            check($sformatf("p1_interval_%0d", i), 32'(n), (i % 4 == 0) ? 32'd162 : 32'd163);
            check($sformatf("p1_mid_%0d", i), 32'(mid_tick), 32'(i == 7));
            check($sformatf("p1_bit_%0d", i), 32'(bit_tick), 32'(i == 15));
            check($sformatf("p1_baud_%0d", i), 32'(baud_clk), 32'(exp_baud));
        end
        check("p1_bit_period", 32'(sum), 32'd2604);

        // ---- write {4,0}: current interval finishes on the old divisor ----
        div_wr = 1'b1;
        div_in = 20'h00040;
        step();
        div_wr = 1'b0;
        wait_tick(n);
        check("p2_old_interval", 32'(n + 1), 32'd162);
        check("p2_div_q", 32'(div_q), 32'h40);
        // os_cnt is 1 here, so the 15th following tick wraps.
        for (int i = 0; i < 15; i++) begin
            wait_tick(n);
            check($sformatf("p2_int_%0d", i), 32'(n), 32'd4);
        end
        check("p2_first_bit", 32'(bit_tick), 1);
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            wait_tick(n);
            sum += n;
            check($sformatf("p2_mid_%0d", i), 32'(mid_tick), 32'(i == 7));
            check($sformatf("p2_bit_%0d", i), 32'(bit_tick), 32'(i == 15));
        end
        check("p2_bit_period", 32'(sum), 32'd64);

        // ---- rejected write {1,0} ----
        div_wr = 1'b1;
        div_in = 20'h00010;
        step();
        div_wr = 1'b0;
        check("p3_err_pulse", 32'(div_err), 1);
        step();
        check("p3_err_clear", 32'(div_err), 0);
        check("p3_div_q_kept", 32'(div_q), 32'h40);
        wait_tick(n);
        check("p3_timing_kept", 32'(n + 2), 32'd4);

        // ---- divisor {4,8}, then resync mid-interval ----
        div_wr = 1'b1;
        div_in = 20'h00048;
        step();
        div_wr = 1'b0;
        wait_tick(n);
        check("p4_old_interval", 32'(n + 1), 32'd4);
        check("p4_div_q", 32'(div_q), 32'h48);
        step();
        step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        check("p4_resync_no_tick", 32'(os_tick), 0);
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            wait_tick(n);
            sum += n;
            check($sformatf("p4_int_%0d", i), 32'(n), (i % 2 == 0) ? 32'd4 : 32'd5);
            check($sformatf("p4_mid_%0d", i), 32'(mid_tick), 32'(i == 7));
            check($sformatf("p4_bit_%0d", i), 32'(bit_tick), 32'(i == 15));
        end
        check("p4_bit_after_resync", 32'(sum), 32'd72);

        // ---- enable low for 10 cycles mid-interval (interval is 4) ----
        step();
        step();
        enable     = 1'b0;
        any_tick   = 1'b0;
        baud_moved = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            any_tick   = any_tick | os_tick | mid_tick | bit_tick;
            baud_moved = baud_moved | (baud_clk !== exp_baud);
        end
        check("p5_no_tick_disabled", 32'(any_tick), 0);
        check("p5_baud_held", 32'(baud_moved), 0);
        enable = 1'b1;
        wait_tick(n);
        check("p5_resume_remaining", 32'(n), 32'd2);

        // ---- write {6,0} while disabled: applies the next cycle ----
        enable = 1'b0;
        div_wr = 1'b1;
        div_in = 20'h00060;
        step();
        div_wr = 1'b0;
        check("p5_div_q_before", 32'(div_q), 32'h48);
        step();
        check("p5_div_q_applied", 32'(div_q), 32'h60);
        enable = 1'b1;
        wait_tick(n);
        check("p5_new_interval", 32'(n), 32'd6);

        // ---- write {3,0} together with resync: immediate ----
        div_wr = 1'b1;
        resync = 1'b1;
        div_in = 20'h00030;
        step();
        div_wr = 1'b0;
        resync = 1'b0;
        check("p6_div_q_immediate", 32'(div_q), 32'h30);
        check("p6_no_tick", 32'(os_tick), 0);
        wait_tick(n);
        check("p6_interval", 32'(n), 32'd3);

        // ---- reset with a write pending ----
        div_wr = 1'b1;
        div_in = 20'h00050;
        step();
        div_wr = 1'b0;
        rst    = 1'b1;
        step();
        rst      = 1'b0;
        exp_baud = 1'b0;
        check("p7_div_q", 32'(div_q), DEF_DIV);
        check("p7_os_tick", 32'(os_tick), 0);
        check("p7_mid_tick", 32'(mid_tick), 0);
        check("p7_bit_tick", 32'(bit_tick), 0);
        check("p7_baud_clk", 32'(baud_clk), 0);
        check("p7_div_err", 32'(div_err), 0);
        wait_tick(n);
        check("p7_first_interval", 32'(n), 32'd162);
        wait_tick(n);
        check("p7_second_interval", 32'(n), 32'd163);
        check("p7_pending_dropped", 32'(div_q), DEF_DIV);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
